// File: rtl/axi_ram_pkg.sv
// Shared constants and FSM state type for the AXI RAM responder.
package axi_ram_pkg;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, RD, WR, WB} state_t;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address and burst legality for FIXED/INCR/WRAP bursts.
module axi_burst_addr_gen
   import axi_ram_pkg::*;
(
   input  logic [31:0] addr,
   input  logic [7:0]  len,
   input  logic [2:0]  size,
   input  logic [1:0]  burst,
   output logic [31:0] next_addr,
   output logic        legal
);
   logic [31:0] incr;
   logic [31:0] wrap_mask;
   logic [31:0] inc_addr;

   assign incr      = 32'd1 << size;
   assign wrap_mask = ((32'(len) + 32'd1) << size) - 32'd1;
   assign inc_addr  = addr + incr;

   always_comb begin
      next_addr = addr;
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_INCR:  next_addr = inc_addr;
         BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (inc_addr & wrap_mask);
         default:     next_addr = addr;
      endcase
   end

   // Only power-of-two wrap spans of 2/4/8/16 beats are meaningful.
   always_comb begin
      legal = 1'b1;
      if (size > 3'd2)
         legal = 1'b0;
      if (burst == BURST_RSVD)
         legal = 1'b0;
      if (burst == BURST_WRAP &&
          !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
         legal = 1'b0;
   end
endmodule

// File: rtl/axi_ram_responder.sv
// AXI3 responder serving single and burst reads/writes from an on-chip word RAM,
// one transaction at a time with round-robin AR/AW arbitration.
module axi_ram_responder
   import axi_ram_pkg::*;
#(
   parameter int    ADDR_WIDTH = 12,
   parameter int    ID_WIDTH   = 4,
   parameter string INIT_FILE  = ""
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ID_WIDTH-1:0] arid,
   input  logic [31:0]         araddr,
   input  logic [7:0]          arlen,
   input  logic [2:0]          arsize,
   input  logic [1:0]          arburst,
   input  logic                arvalid,
   output logic                arready,
   output logic [ID_WIDTH-1:0] rid,
   output logic [31:0]         rdata,
   output logic [1:0]          rresp,
   output logic                rlast,
   output logic                rvalid,
   input  logic                rready,
   input  logic [ID_WIDTH-1:0] awid,
   input  logic [31:0]         awaddr,
   input  logic [7:0]          awlen,
   input  logic [2:0]          awsize,
   input  logic [1:0]          awburst,
   input  logic                awvalid,
   output logic                awready,
   input  logic [ID_WIDTH-1:0] wid,
   input  logic [31:0]         wdata,
   input  logic [3:0]          wstrb,
   input  logic                wlast,
   input  logic                wvalid,
   output logic                wready,
   output logic [ID_WIDTH-1:0] bid,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready
);
   // state | meaning
   // IDLE  | no transaction; AR/AW arbitration drives arready/awready
   // RD    | streaming R beats, one RAM read per cycle
   // WR    | accepting W beats into the RAM
   // WB    | presenting the write response
   localparam int DEPTH          = 1 << ADDR_WIDTH;
   localparam bit HAS_INIT_IMAGE = (INIT_FILE != "");

   logic [31:0]           mem [DEPTH];
   logic [31:0]           ram_q;

   state_t                state;
   logic                  prio_wr;
   logic [ID_WIDTH-1:0]   id_q;
   logic [31:0]           addr_q;
   logic [7:0]            len_q;
   logic [7:0]            beat_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic                  bad_q;
   logic                  werr_q;

   logic                  grant_rd;
   logic                  grant_wr;
   logic                  ar_hs;
   logic                  aw_hs;
   logic                  r_hs;
   logic                  w_hs;
   logic                  beat_last;
   logic                  wlast_bad;
   logic [31:0]           g_addr;
   logic [7:0]            g_len;
   logic [2:0]            g_size;
   logic [1:0]            g_burst;
   logic [31:0]           next_addr;
   logic                  legal;
   logic [31:0]           rd_addr;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic [ADDR_WIDTH-1:0] wr_idx;
   logic                  unused_inputs;

   // Preloading is attached outside this block; wid is not needed with one write in flight.
   assign unused_inputs = ^{wid, HAS_INIT_IMAGE};

   always_comb begin
      grant_rd = 1'b0;
      grant_wr = 1'b0;
      if (state == IDLE && !rst) begin
         if (arvalid && awvalid) begin
            grant_rd = !prio_wr;
            grant_wr = prio_wr;
         end else begin
            grant_rd = arvalid;
            grant_wr = awvalid;
         end
      end
   end

   assign arready   = grant_rd;
   assign awready   = grant_wr;
   assign ar_hs     = arvalid && grant_rd;
   assign aw_hs     = awvalid && grant_wr;
   assign r_hs      = rvalid && rready;
   assign w_hs      = (state == WR) && wvalid && wready && !rst;
   assign beat_last = (beat_q == len_q);
   assign wlast_bad = (wlast != beat_last);

   // In IDLE the generator checks the incoming request; otherwise it steps the live burst.
   always_comb begin
      g_addr  = addr_q;
      g_len   = len_q;
      g_size  = size_q;
      g_burst = burst_q;
      if (state == IDLE) begin
         if (grant_wr) begin
            g_addr  = awaddr;
            g_len   = awlen;
            g_size  = awsize;
            g_burst = awburst;
         end else begin
            g_addr  = araddr;
            g_len   = arlen;
            g_size  = arsize;
            g_burst = arburst;
         end
      end
   end

   axi_burst_addr_gen u_addr_gen (
      .addr      (g_addr),
      .len       (g_len),
      .size      (g_size),
      .burst     (g_burst),
      .next_addr (next_addr),
      .legal     (legal)
   );

   always_comb begin
      rd_addr = addr_q;
      if (ar_hs)
         rd_addr = araddr;
      else if (r_hs)
         rd_addr = next_addr;
   end

   assign rd_idx = rd_addr[ADDR_WIDTH+1:2];
   assign wr_idx = addr_q[ADDR_WIDTH+1:2];

   // Re-reading the current word while stalled keeps rdata steady without a hold mux.
   always_ff @(posedge clk) begin
      if (w_hs && !bad_q) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i])
               mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      ram_q <= mem[rd_idx];
   end

   assign rdata = bad_q ? 32'h0 : ram_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         prio_wr <= 1'b0;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         size_q  <= '0;
         burst_q <= '0;
         bad_q   <= 1'b0;
         werr_q  <= 1'b0;
         rid     <= '0;
         rresp   <= RESP_OKAY;
         rlast   <= 1'b0;
         rvalid  <= 1'b0;
         wready  <= 1'b0;
         bid     <= '0;
         bresp   <= RESP_OKAY;
         bvalid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ar_hs) begin
                  state   <= RD;
                  prio_wr <= 1'b1;
                  addr_q  <= araddr;
                  len_q   <= arlen;
                  size_q  <= arsize;
                  burst_q <= arburst;
                  beat_q  <= '0;
                  bad_q   <= !legal;
                  rid     <= arid;
                  rresp   <= legal ? RESP_OKAY : RESP_SLVERR;
                  rlast   <= (arlen == 8'd0);
                  rvalid  <= 1'b1;
               end else if (aw_hs) begin
                  state   <= WR;
                  prio_wr <= 1'b0;
                  id_q    <= awid;
                  addr_q  <= awaddr;
                  len_q   <= awlen;
                  size_q  <= awsize;
                  burst_q <= awburst;
                  beat_q  <= '0;
                  bad_q   <= !legal;
                  werr_q  <= 1'b0;
                  wready  <= 1'b1;
               end
            end
            RD: begin
               if (r_hs) begin
                  if (beat_last) begin
                     state  <= IDLE;
                     rvalid <= 1'b0;
                     rlast  <= 1'b0;
                  end else begin
                     beat_q <= beat_q + 8'd1;
                     addr_q <= next_addr;
                     rlast  <= ((beat_q + 8'd1) == len_q);
                  end
               end
            end
            WR: begin
               if (w_hs) begin
                  beat_q <= beat_q + 8'd1;
                  addr_q <= next_addr;
                  if (wlast_bad)
                     werr_q <= 1'b1;
                  if (beat_last) begin
                     state  <= WB;
                     wready <= 1'b0;
                     bvalid <= 1'b1;
                     bid    <= id_q;
                     bresp  <= (bad_q || werr_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                  end
               end
            end
            WB: begin
               if (bready) begin
                  state  <= IDLE;
                  bvalid <= 1'b0;
                  bresp  <= RESP_OKAY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed bench for axi_ram_responder: word-level memory model, expected-beat queues,
// and a negedge compare process on every valid R/B cycle.
module tb_axi_ram_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  arid, awid, wid, rid, bid;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize;
   logic [1:0]  arburst, awburst, rresp, bresp;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [3:0]  wstrb;

   always #5 clk = ~clk;

   axi_ram_responder dut (
      .clk(clk), .rst(rst),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } r_exp_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_exp_t;

   r_exp_t      rq [$];
   b_exp_t      bq [$];
   logic [31:0] rcap_d [$];
   logic        rcap_l [$];
   logic [1:0]  rcap_r [$];
   logic [1:0]  bcap [$];
   logic [31:0] mdl [4096];
   logic [31:0] wbuf [16];
   logic [3:0]  sbuf [16];
   logic [31:0] wrap_exp [4];
   logic        rmode = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: handshake not seen within cycle budget, expected it to occur", name);
   endtask

   // Reference rules: address of beat k and burst legality.
   function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                             input int burst, input int k);
      int unsigned incr, span;
      logic [31:0] base;
      incr = 32'd1 << size;
      if (burst == 0) return a;
      if (burst == 1) return a + k * incr;
      span = (len + 1) * incr;
      base = a - (a % span);
      return base + ((a - base + k * incr) % span);
   endfunction

   function automatic bit legal_burst(input int len, input int size, input int burst);
      if (size > 2 || burst == 3) return 1'b0;
      if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) & 32'hFFF);
   endfunction

   task automatic model_write(input logic [3:0] id, input logic [31:0] a, input int len,
                              input int size, input int burst, input int wlast_beat);
      bit ok;
      ok = legal_burst(len, size, burst);
      if (ok)
         for (int k = 0; k <= len; k++)
            for (int b = 0; b < 4; b++)
               if (sbuf[k][b])
                  mdl[widx(beat_addr(a, len, size, burst, k))][8*b +: 8] = wbuf[k][8*b +: 8];
      bq.push_back('{id: id, resp: (ok && wlast_beat == len) ? 2'b00 : 2'b10});
   endtask

   task automatic model_read(input logic [3:0] id, input logic [31:0] a, input int len,
                             input int size, input int burst);
      bit ok;
      ok = legal_burst(len, size, burst);
      for (int k = 0; k <= len; k++)
         rq.push_back('{data: ok ? mdl[widx(beat_addr(a, len, size, burst, k))] : 32'h0,
                        resp: ok ? 2'b00 : 2'b10, last: (k == len), id: id});
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input int len,
                          input int size, input int burst);
      int n;
      n = 0;
      arid = id; araddr = a; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
      arvalid = 1'b1;
      do begin @(negedge clk); n++; end while (!arready && n < 50);
      if (!arready) timeout("ar_handshake");
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      chk("r_latency_rvalid", 32'(rvalid), 32'h1);
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input int len,
                          input int size, input int burst);
      int n;
      n = 0;
      awid = id; awaddr = a; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
      awvalid = 1'b1;
      do begin @(negedge clk); n++; end while (!awready && n < 50);
      if (!awready) timeout("aw_handshake");
      @(posedge clk); #1;
      awvalid = 1'b0;
   endtask

   task automatic send_w(input int len, input int wlast_beat);
      int n;
      for (int k = 0; k <= len; k++) begin
         wvalid = 1'b1; wdata = wbuf[k]; wstrb = sbuf[k]; wlast = (k == wlast_beat);
         wid = 4'hF;
         n = 0;
         do begin @(negedge clk); n++; end while (!wready && n < 50);
         if (!wready) timeout("w_handshake");
         @(posedge clk); #1;
      end
      wvalid = 1'b0;
      wlast = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin @(posedge clk); n++; end
      if (rq.size() != 0 || bq.size() != 0) begin
         timeout("drain_responses");
         rq.delete();
         bq.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic axi_write(input logic [3:0] id, input logic [31:0] a, input int len,
                            input int size, input int burst, input int wlast_beat);
      model_write(id, a, len, size, burst, wlast_beat);
      send_aw(id, a, len, size, burst);
      send_w(len, wlast_beat);
      drain();
   endtask

   task automatic axi_read(input logic [3:0] id, input logic [31:0] a, input int len,
                           input int size, input int burst);
      model_read(id, a, len, size, burst);
      send_ar(id, a, len, size, burst);
      drain();
   endtask

   task automatic clear_caps();
      rcap_d.delete(); rcap_l.delete(); rcap_r.delete(); bcap.delete();
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Compare process: every cycle R or B is valid, check against the head of its queue.
   initial forever begin
      r_exp_t re;
      b_exp_t be;
      @(negedge clk);
      if (!rst && rvalid) begin
         if (rq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL r_unexpected: rvalid with rdata 0x%08h, expected no beat", rdata);
         end else begin
            re = rq[0];
            chk("r_data", rdata, re.data);
            chk("r_resp", 32'(rresp), 32'(re.resp));
            chk("r_last", 32'(rlast), 32'(re.last));
            chk("r_id", 32'(rid), 32'(re.id));
            if (rready) begin
               rcap_d.push_back(rdata); rcap_l.push_back(rlast); rcap_r.push_back(rresp);
               re = rq.pop_front();
            end
         end
      end
      if (!rst && bvalid) begin
         if (bq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL b_unexpected: bvalid with bresp %0d, expected no response", bresp);
         end else begin
            be = bq[0];
            chk("b_resp", 32'(bresp), 32'(be.resp));
            chk("b_id", 32'(bid), 32'(be.id));
            if (bready) begin
               bcap.push_back(bresp);
               be = bq.pop_front();
            end
         end
      end
   end

   initial begin
      rready = 1'b1;
      forever begin
         @(posedge clk); #1;
         rready = rmode ? ~rready : 1'b1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at 100us, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst = 1'b1; bready = 1'b1;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
      wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
      arvalid = 1'b1; awvalid = 1'b1;
      wrap_exp = '{32'h38, 32'h3C, 32'h30, 32'h34};

      // Reset state, with both request valids held high.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arready", 32'(arready), 0);
      chk("rst_awready", 32'(awready), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_bvalid", 32'(bvalid), 0);
      chk("rst_wready", 32'(wready), 0);
      chk("rst_rlast", 32'(rlast), 0);
      chk("rst_rresp", 32'(rresp), 0);
      chk("rst_bresp", 32'(bresp), 0);
      @(posedge clk); #1;
      arvalid = 1'b0; awvalid = 1'b0; rst = 1'b0;

      // 1: single write then read.
      clear_caps();
      wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
      axi_write(4'h1, 32'h1000, 0, 2, 1, 0);
      axi_read(4'h2, 32'h1000, 0, 2, 1);
      chk("t1_bresp", 32'(bcap[0]), 0);
      chk("t1_rdata", rcap_d[0], 32'hDEADBEEF);
      chk("t1_rlast", 32'(rcap_l[0]), 1);

      // 2: INCR burst write, read back with rready toggling.
      clear_caps();
      for (int k = 0; k < 4; k++) begin wbuf[k] = 32'(k + 1); sbuf[k] = 4'hF; end
      axi_write(4'h3, 32'h20, 3, 2, 1, 3);
      rmode = 1'b1;
      axi_read(4'h4, 32'h20, 3, 2, 1);
      rmode = 1'b0;
      chk("t2_beats", 32'(rcap_d.size()), 4);
      for (int k = 0; k < 4; k++) begin
         chk("t2_rdata", rcap_d[k], 32'(k + 1));
         chk("t2_rlast", 32'(rcap_l[k]), (k == 3) ? 32'h1 : 32'h0);
      end

      // 3: WRAP read starting mid-window.
      clear_caps();
      wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
      axi_write(4'h5, 32'h30, 3, 2, 1, 3);
      for (int k = 0; k < 4; k++)
         chk("t3_model_wrap_addr", beat_addr(32'h38, 3, 2, 2, k), wrap_exp[k]);
      axi_read(4'h6, 32'h38, 3, 2, 2);
      chk("t3_d0", rcap_d[0], 32'hC);
      chk("t3_d1", rcap_d[1], 32'hD);
      chk("t3_d2", rcap_d[2], 32'hA);
      chk("t3_d3", rcap_d[3], 32'hB);

      // 4: byte-strobe merge, then an illegal WRAP length write is suppressed.
      clear_caps();
      wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
      axi_write(4'h7, 32'h40, 0, 2, 1, 0);
      wbuf[0] = 32'h00AB0000; sbuf[0] = 4'b0100;
      axi_write(4'h7, 32'h40, 0, 2, 1, 0);
      for (int k = 0; k < 3; k++) begin wbuf[k] = 32'hFFFFFFFF; sbuf[k] = 4'hF; end
      axi_write(4'h8, 32'h40, 2, 2, 2, 2);
      axi_read(4'h9, 32'h40, 0, 2, 1);
      chk("t4_illegal_bresp", 32'(bcap[2]), 2);
      chk("t4_merge", rcap_d[0], 32'h11AB3344);

      // 5: simultaneous AR/AW twice after reset; early wlast on a 2-beat write.
      pulse_reset();
      clear_caps();
      arid = 4'h5; araddr = 32'h1000; arlen = 8'd0; arsize = 3'd2; arburst = 2'd1;
      awid = 4'h6; awaddr = 32'h60; awlen = 8'd1; awsize = 3'd2; awburst = 2'd1;
      arvalid = 1'b1; awvalid = 1'b1;
      model_read(4'h5, 32'h1000, 0, 2, 1);
      @(negedge clk);
      chk("t5_tie1_arready", 32'(arready), 1);
      chk("t5_tie1_awready", 32'(awready), 0);
      @(posedge clk); #1;
      arid = 4'h7; araddr = 32'h60; arlen = 8'd1;
      @(negedge clk);
      chk("t5_rvalid", 32'(rvalid), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_tie2_awready", 32'(awready), 1);
      chk("t5_tie2_arready", 32'(arready), 0);
      @(posedge clk); #1;
      awvalid = 1'b0;
      wbuf[0] = 32'h60600001; wbuf[1] = 32'h60600002; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
      model_write(4'h6, 32'h60, 1, 2, 1, 0);
      send_w(1, 0);
      model_read(4'h7, 32'h60, 1, 2, 1);
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 50);
      if (!arready) timeout("t5_ar_after_write");
      @(posedge clk); #1;
      arvalid = 1'b0;
      drain();
      chk("t5_bresp", 32'(bcap[0]), 2);
      chk("t5_first_read", rcap_d[0], 32'hDEADBEEF);
      chk("t5_beat0_written", rcap_d[1], 32'h60600001);
      chk("t5_beat1_written", rcap_d[2], 32'h60600002);

      // 6: oversize read, then reset in the middle of an 8-beat read.
      clear_caps();
      axi_read(4'hA, 32'h1000, 1, 3, 1);
      chk("t6_beats", 32'(rcap_d.size()), 2);
      chk("t6_rdata", rcap_d[1], 32'h0);
      chk("t6_rresp", 32'(rcap_r[1]), 2);
      for (int k = 0; k < 8; k++) begin wbuf[k] = 32'h51000000 + 32'(k); sbuf[k] = 4'hF; end
      axi_write(4'hB, 32'h100, 7, 2, 1, 7);
      model_read(4'hC, 32'h100, 7, 2, 1);
      send_ar(4'hC, 32'h100, 7, 2, 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      rq.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_rvalid", 32'(rvalid), 0);
      chk("t6_rst_rlast", 32'(rlast), 0);
      chk("t6_rst_wready", 32'(wready), 0);
      @(posedge clk); #1;
      clear_caps();
      axi_read(4'hD, 32'h108, 0, 2, 1);
      chk("t6_after_rst", rcap_d[0], 32'h51000002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/axi_ram_responder.md
Name: axi_ram_responder

Overview:
AXI3-compatible slave that answers single-beat and burst read/write transactions against an on-chip word-addressed RAM. It is the responder end of the CPU-side AXI master bridge and serves as boot/scratch memory and as a bench target for that master. It handles one transaction at a time, with read/write arbitration, byte strobes and INCR/FIXED/WRAP address generation.

Parameters:
ADDR_WIDTH, 12, log2 of RAM depth in 32-bit words (default 16 KiB); word index = addr[ADDR_WIDTH+1:2], upper address bits ignored (aliasing)
ID_WIDTH, 4, width of arid/rid/awid/bid/wid
INIT_FILE, "", optional hex image loaded at elaboration; empty = RAM contents undefined

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/32/8/3/2  read address channel payload
arvalid  in  1 ; arready  out  1
rid  out  ID_WIDTH ; rdata  out  32 ; rresp  out  2 ; rlast  out  1 ; rvalid  out  1 ; rready  in  1
awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/32/8/3/2  write address channel payload
awvalid  in  1 ; awready  out  1
wid  in  ID_WIDTH ; wdata  in  32 ; wstrb  in  4 ; wlast  in  1 ; wvalid  in  1 ; wready  out  1
bid  out  ID_WIDTH ; bresp  out  2 ; bvalid  out  1 ; bready  in  1
(arlock/arcache/arprot and aw equivalents are not ports; ignored by design.)

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. During and after reset: state IDLE, rvalid=bvalid=0, wready=0, rlast=0, rresp=bresp=0, beat counter=0, grant pointer=read. arready/awready are 0 while rst=1.
- FSM: IDLE, RD, WR, WB.
- IDLE: arready = awready-not-granted; if only one valid, grant it; if both, grant opposite of last grant (round-robin; first tie after reset goes to read). Only the granted ready is 1. Handshake latches id, addr, len, size, burst; beat counter = 0.
- RD: AR handshake at cycle T -> beat 0 rvalid=1 at T+1. RAM is read synchronously every cycle at (handshake ? next_addr : cur_addr), so rdata holds under rready=0 and beats stream back-to-back with no bubble. rlast=1 on beat == len. Handshake on last beat -> IDLE next cycle, rvalid=0.
- WR: wready=1. Each wvalid&&wready beat writes the RAM word, byte lane i enabled by wstrb[i]. wid is ignored. On counted beat == len -> WB. wlast does not end the burst. A wlast mismatch (high before the last beat, or low on it) sets a sticky error flag.
- WB: bvalid=1, bid=latched awid; bresp=SLVERR(2'b10) if error flag set else OKAY; bready handshake -> IDLE.
- Address generation (sub-module), incr = 1<<size:
  - FIXED: address constant.
  - INCR: addr+incr.
  - WRAP: boundary = (len+1)*incr; next = (addr & ~(boundary-1)) | ((addr+incr) & (boundary-1)).
- Error cases -> SLVERR on every R beat / on B; writes suppressed; reads return 0:
  - size > 2;
  - burst == 2'b11 (reserved);
  - WRAP with len not in {1,3,7,15}.
  The transaction still completes with len+1 beats.
- Narrow transfers: full 32-bit word returned on reads; writes obey wstrb only.
- Same-cycle write then read of the same word: the read started after WB sees the new data. No combinational path from any valid to any ready except the IDLE arbitration.
- rst mid-burst: transaction abandoned, RAM keeps the writes already done, all outputs at reset values next cycle.

Decomposition:
- Package axi_ram_pkg: BURST_FIXED/INCR/WRAP constants, RESP_OKAY/RESP_SLVERR constants, state enum type (IDLE, RD, WR, WB).
- Sub-module axi_burst_addr_gen: purely combinational next-address and legality check from addr, len, size, burst.
- RAM inferred in the top level as a byte-enabled array.

Test Plan:
1. Single write 0x1000 data 0xDEADBEEF wstrb 4'hF, then single read 0x1000 -> rdata 0xDEADBEEF, rresp 0, rlast 1, rvalid at AR handshake+1.
2. INCR write len 3 size 2 at 0x20 (data 1..4), INCR read len 3 with rready low every other cycle -> beats 1,2,3,4 in order, rdata stable while stalled, rlast only on 4th.
3. WRAP read len 3 size 2 at 0x38 after filling 0x30..0x3C with A,B,C,D -> addresses 0x38,0x3C,0x30,0x34, data C,D,A,B.
4. Write 0x40 with wstrb 4'b0100 data 0x00AB0000 over 0x11223344 -> readback 0x11AB3344.
5. arvalid and awvalid asserted together twice after reset -> first grant read, second grant write; write with wlast on beat 0 of len 1 -> bresp 2'b10, both beats still written.
6. Read with arsize 3 -> two beats for len 1, rresp 2'b10, rdata 0; rst asserted mid INCR len 7 read -> rvalid 0 next cycle, next transaction serviced normally.
